// File: rtl/dmem_bridge.sv
// Bridge from the load/store pipeline D-mem port to the doubleword-aligned external data bus.
// Latency: 4 cycles minimum accept-to-accept (bus request +1, bus completion +2, dm response +3).
// Backpressure: one request outstanding; dm_req_ready low until the response pulse has gone; bus_valid held until bus_ready.
module dmem_bridge #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] dm_req_addr,
   input  logic [63:0] dm_req_wdata,
   input  logic [7:0]  dm_req_wmask,
   input  logic        dm_req_wen,
   input  logic        dm_req_valid,
   output logic        dm_req_ready,
   output logic [63:0] dm_resp_rdata,
   output logic        dm_resp_valid,
   output logic [63:0] bus_addr,
   output logic [63:0] bus_wdata,
   output logic [7:0]  bus_wmask,
   output logic        bus_wen,
   output logic        bus_valid,
   input  logic        bus_ready,
   input  logic [63:0] bus_rdata,
   input  logic        bus_rvalid,
   output logic        bus_timeout
);

   typedef enum logic [1:0] {IDLE, BUS_REQ, WAIT_RESP, RESP} state_t;

   // Counter value seen on the last permitted WAIT_RESP cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state;
   state_t            state_nxt;
   logic [63:0]       addr_q;
   logic [CNT_W-1:0]  cnt;
   logic              accept;
   logic              bus_accept;
   logic              rsp_hit;
   logic              tmo_hit;

   // Full byte address is kept; the bus only ever sees the doubleword base.
   assign bus_addr = addr_q & ~64'h7;

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and handshake decode.
   always_comb begin
      state_nxt     = state;
      dm_req_ready  = 1'b0;
      dm_resp_valid = 1'b0;
      bus_valid     = 1'b0;
      bus_timeout   = 1'b0;
      accept        = 1'b0;
      bus_accept    = 1'b0;
      rsp_hit       = 1'b0;
      tmo_hit       = 1'b0;
      case (state)
         IDLE: begin
            dm_req_ready = !rst;
            if (dm_req_valid && !rst) begin
               accept    = 1'b1;
               state_nxt = BUS_REQ;
            end
         end
         BUS_REQ: begin
            bus_valid = 1'b1;
            if (bus_ready) begin
               bus_accept = 1'b1;
               state_nxt  = WAIT_RESP;
            end
         end
         WAIT_RESP: begin
            // A real completion wins over a timeout landing in the same cycle.
            if (bus_rvalid) begin
               rsp_hit   = 1'b1;
               state_nxt = RESP;
            end else if (cnt == CNT_LAST) begin
               tmo_hit     = 1'b1;
               bus_timeout = !rst;
               state_nxt   = RESP;
            end
         end
         RESP: begin
            dm_resp_valid = 1'b1;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, timeout counter and registered response data.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q        <= '0;
         bus_wdata     <= '0;
         bus_wmask     <= '0;
         bus_wen       <= 1'b0;
         cnt           <= '0;
         dm_resp_rdata <= '0;
      end else begin
         if (accept) begin
            addr_q    <= dm_req_addr;
            bus_wdata <= dm_req_wdata;
            bus_wmask <= dm_req_wen ? dm_req_wmask : 8'h00;
            bus_wen   <= dm_req_wen;
         end
         if (bus_accept)
            cnt <= '0;
         else if (state == WAIT_RESP)
            cnt <= cnt + CNT_W'(1);
         if (rsp_hit)
            dm_resp_rdata <= bus_wen ? 64'h0 : bus_rdata;
         else if (tmo_hit)
            dm_resp_rdata <= 64'h0;
      end
   end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge built with a 4-cycle response timeout.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Each task covers one scenario and checks its own expectations inline.
module tb_dmem_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] dm_req_addr;
   logic [63:0] dm_req_wdata;
   logic [7:0]  dm_req_wmask;
   logic        dm_req_wen;
   logic        dm_req_valid;
   logic        dm_req_ready;
   logic [63:0] dm_resp_rdata;
   logic        dm_resp_valid;
   logic [63:0] bus_addr;
   logic [63:0] bus_wdata;
   logic [7:0]  bus_wmask;
   logic        bus_wen;
   logic        bus_valid;
   logic        bus_ready;
   logic [63:0] bus_rdata;
   logic        bus_rvalid;
   logic        bus_timeout;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dmem_bridge #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata),
      .dm_req_wmask(dm_req_wmask), .dm_req_wen(dm_req_wen),
      .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
      .dm_resp_rdata(dm_resp_rdata), .dm_resp_valid(dm_resp_valid),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
      .bus_wen(bus_wen), .bus_valid(bus_valid), .bus_ready(bus_ready),
      .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .bus_timeout(bus_timeout)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Present a request in IDLE and advance into BUS_REQ.
   task automatic issue(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m, input logic w);
      dm_req_addr = a; dm_req_wdata = d; dm_req_wmask = m; dm_req_wen = w; dm_req_valid = 1'b1;
      step;
      dm_req_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; dm_req_valid = 1'b0; dm_req_addr = '0; dm_req_wdata = '0; dm_req_wmask = '0;
      dm_req_wen = 1'b0; bus_ready = 1'b0; bus_rdata = '0; bus_rvalid = 1'b0;
      step; step;
      n_tests++; if (dm_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_rst got %b want 0", dm_req_ready); end
      n_tests++; if ({bus_valid, dm_resp_valid, bus_timeout, bus_wen} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {bus_valid, dm_resp_valid, bus_timeout, bus_wen}); end
      n_tests++; if ({bus_addr, bus_wdata, dm_resp_rdata, bus_wmask} !== 200'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", {bus_addr, bus_wdata, dm_resp_rdata, bus_wmask}); end
      rst = 1'b0;
      #1;
      n_tests++; if (dm_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got %b want 1", dm_req_ready); end
   endtask

   task automatic test_load;
      bus_ready = 1'b1;
      n_tests++; if (dm_req_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_idle got %b want 1", dm_req_ready); end
      issue(64'h8000_0013, 64'h0, 8'h02, 1'b0);                       // N+1
      n_tests++; if (bus_valid !== 1'b1) begin n_fail++; $display("FAIL load_bus_valid got %b want 1", bus_valid); end
      n_tests++; if (bus_addr !== 64'h8000_0010) begin n_fail++; $display("FAIL load_bus_addr got %h want 80000010", bus_addr); end
      n_tests++; if ({bus_wmask, bus_wen} !== 9'h0) begin n_fail++; $display("FAIL load_wmask_wen got %h want 0", {bus_wmask, bus_wen}); end
      n_tests++; if ({dm_req_ready, dm_resp_valid} !== 2'b00) begin n_fail++; $display("FAIL load_n1_flags got %b want 00", {dm_req_ready, dm_resp_valid}); end
      step;                                                           // N+2
      n_tests++; if ({bus_valid, dm_req_ready, dm_resp_valid} !== 3'b000) begin n_fail++; $display("FAIL load_n2_flags got %b want 000", {bus_valid, dm_req_ready, dm_resp_valid}); end
      bus_rvalid = 1'b1; bus_rdata = 64'h1122334455667788;
      step;                                                           // N+3
      bus_rvalid = 1'b0; bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      n_tests++; if ({dm_resp_valid, dm_req_ready} !== 2'b10) begin n_fail++; $display("FAIL load_n3_flags got %b want 10", {dm_resp_valid, dm_req_ready}); end
      n_tests++; if (dm_resp_rdata !== 64'h1122334455667788) begin n_fail++; $display("FAIL load_rdata got %h want 1122334455667788", dm_resp_rdata); end
      step;                                                           // N+4
      n_tests++; if ({dm_resp_valid, dm_req_ready} !== 2'b01) begin n_fail++; $display("FAIL load_n4_flags got %b want 01", {dm_resp_valid, dm_req_ready}); end
   endtask

   task automatic test_store;
      bus_ready = 1'b1;
      issue(64'h4000_0105, 64'hAAAA_AAAA_AAAA_AAAA, 8'hF0, 1'b1);
      n_tests++; if (bus_addr !== 64'h4000_0100) begin n_fail++; $display("FAIL store_bus_addr got %h want 40000100", bus_addr); end
      n_tests++; if ({bus_wen, bus_wmask} !== 9'h1F0) begin n_fail++; $display("FAIL store_wen_wmask got %h want 1f0", {bus_wen, bus_wmask}); end
      n_tests++; if (bus_wdata !== 64'hAAAA_AAAA_AAAA_AAAA) begin n_fail++; $display("FAIL store_wdata got %h want aaaaaaaaaaaaaaaa", bus_wdata); end
      step;
      bus_rvalid = 1'b1; bus_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      step;
      bus_rvalid = 1'b0;
      n_tests++; if (dm_resp_valid !== 1'b1) begin n_fail++; $display("FAIL store_resp_valid got %b want 1", dm_resp_valid); end
      n_tests++; if (dm_resp_rdata !== 64'h0) begin n_fail++; $display("FAIL store_rdata got %h want 0", dm_resp_rdata); end
      step;
   endtask

   task automatic test_backpressure;
      bus_ready = 1'b0;
      issue(64'h0000_0001_2345_678F, 64'h5555_0000_5555_0000, 8'hFF, 1'b0);
      for (int i = 0; i < 6; i++) begin
         n_tests++;
         if ({bus_valid, bus_addr, bus_wmask, bus_wen} !== {1'b1, 64'h0000_0001_2345_6788, 8'h00, 1'b0}) begin
            n_fail++; $display("FAIL bp_hold cycle %0d got v=%b a=%h m=%h w=%b want v=1 a=123456788 m=00 w=0", i, bus_valid, bus_addr, bus_wmask, bus_wen);
         end
         if (i == 5) bus_ready = 1'b1;
         step;
      end
      n_tests++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL bp_deassert got %b want 0", bus_valid); end
      bus_rvalid = 1'b1; bus_rdata = 64'hCAFE_F00D_0123_4567;
      step;
      bus_rvalid = 1'b0;
      n_tests++; if ({dm_resp_valid, dm_resp_rdata} !== {1'b1, 64'hCAFE_F00D_0123_4567}) begin n_fail++; $display("FAIL bp_resp got %b/%h want 1/cafef00d01234567", dm_resp_valid, dm_resp_rdata); end
      step;
      n_tests++; if (dm_resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_single_resp got %b want 0", dm_resp_valid); end
   endtask

   task automatic test_timeout;
      bus_ready = 1'b1; bus_rdata = 64'h7777_7777_7777_7777;
      issue(64'h20, 64'h0, 8'h00, 1'b0);
      step;                                                           // WAIT_RESP cycle 1
      for (int i = 1; i < 4; i++) begin
         n_tests++; if ({bus_timeout, dm_resp_valid} !== 2'b00) begin n_fail++; $display("FAIL to_early cycle %0d got %b want 00", i, {bus_timeout, dm_resp_valid}); end
         step;
      end
      n_tests++; if ({bus_timeout, dm_resp_valid} !== 2'b10) begin n_fail++; $display("FAIL to_pulse got %b want 10", {bus_timeout, dm_resp_valid}); end
      step;
      n_tests++; if ({bus_timeout, dm_resp_valid, dm_resp_rdata} !== {2'b01, 64'h0}) begin n_fail++; $display("FAIL to_resp got %b/%b/%h want 0/1/0", bus_timeout, dm_resp_valid, dm_resp_rdata); end
      step; step;
      bus_rvalid = 1'b1;
      step;
      bus_rvalid = 1'b0;
      n_tests++; if ({dm_resp_valid, dm_req_ready, bus_valid} !== 3'b010) begin n_fail++; $display("FAIL to_late_rvalid got %b want 010", {dm_resp_valid, dm_req_ready, bus_valid}); end
   endtask

   task automatic test_simultaneous;
      bus_ready = 1'b1;
      issue(64'h48, 64'h0, 8'h00, 1'b0);
      step; step; step; step;                                         // WAIT_RESP cycle 4
      bus_rvalid = 1'b1; bus_rdata = 64'h5;
      #1;
      n_tests++; if (bus_timeout !== 1'b0) begin n_fail++; $display("FAIL sim_timeout got %b want 0", bus_timeout); end
      step;
      bus_rvalid = 1'b0;
      n_tests++; if ({dm_resp_valid, dm_resp_rdata} !== {1'b1, 64'h5}) begin n_fail++; $display("FAIL sim_resp got %b/%h want 1/5", dm_resp_valid, dm_resp_rdata); end
      step;
   endtask

   task automatic test_reset_mid;
      bus_ready = 1'b1;
      issue(64'h100, 64'h0, 8'h00, 1'b0);
      step;                                                           // WAIT_RESP
      rst = 1'b1;
      step;
      rst = 1'b0;
      bus_rvalid = 1'b1; bus_rdata = 64'h9999;
      #1;
      n_tests++; if ({dm_resp_valid, bus_valid, dm_req_ready} !== 3'b001) begin n_fail++; $display("FAIL rstmid_after got %b want 001", {dm_resp_valid, bus_valid, dm_req_ready}); end
      step;
      bus_rvalid = 1'b0;
      n_tests++; if (dm_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_resp got %b want 0", dm_resp_valid); end
   endtask

   task automatic test_back_to_back;
      logic [63:0] addrs [2];
      logic [63:0] datas [2];
      addrs[0] = 64'h1000_0004; datas[0] = 64'h0102_0304_0506_0708;
      addrs[1] = 64'h2000_000F; datas[1] = 64'hF0E0_D0C0_B0A0_9080;
      bus_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         n_tests++; if (dm_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready req %0d got %b want 1", k, dm_req_ready); end
         issue(addrs[k], 64'h0, 8'h00, 1'b0);
         n_tests++; if (bus_addr !== (addrs[k] & ~64'h7)) begin n_fail++; $display("FAIL b2b_addr req %0d got %h want %h", k, bus_addr, addrs[k] & ~64'h7); end
         step;
         bus_rvalid = 1'b1; bus_rdata = datas[k];
         step;
         bus_rvalid = 1'b0;
         n_tests++; if ({dm_resp_valid, dm_resp_rdata} !== {1'b1, datas[k]}) begin n_fail++; $display("FAIL b2b_resp req %0d got %b/%h want 1/%h", k, dm_resp_valid, dm_resp_rdata, datas[k]); end
         step;
      end
   endtask

   initial begin
      test_reset;
      test_load;
      test_store;
      test_backpressure;
      test_timeout;
      test_simultaneous;
      test_reset_mid;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits between the load/store pipeline's D-mem interface and the external data bus. Directly downstream of the load/store pipeline.
- Accepts one dm request at a time, issues it as a doubleword-aligned bus transaction and waits for the bus completion. Returns exactly one dm response per accepted request: a one-cycle pulse carrying the raw 64-bit read data.
- Includes a response timeout so a dead bus cannot hang the core.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of cycles in WAIT_RESP before the access is force-completed. Must be at least 1.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- dm_req_addr  in  64  byte address from the load/store pipeline
- dm_req_wdata  in  64  write data, already lane-replicated
- dm_req_wmask  in  8  byte write enables
- dm_req_wen  in  1  1 = store, 0 = load
- dm_req_valid  in  1  request valid
- dm_req_ready  out  1  bridge can accept a request
- dm_resp_rdata  out  64  read data; 0 for stores and timeouts
- dm_resp_valid  out  1  one-cycle completion pulse
- bus_addr  out  64  {addr[63:3],3'b000}
- bus_wdata  out  64  latched write data
- bus_wmask  out  8  latched mask; 8'h00 on loads
- bus_wen  out  1  latched write enable
- bus_valid  out  1  bus request valid
- bus_ready  in  1  bus accepts request
- bus_rdata  in  64  bus read data
- bus_rvalid  in  1  bus completion (sent for both loads and stores)
- bus_timeout  out  1  one-cycle pulse when an access times out

Behaviour:
- Reset state: IDLE. All of the following are 0: dm_req_ready, dm_resp_valid, dm_resp_rdata, bus_valid, bus_addr, bus_wdata, bus_wmask, bus_wen, bus_timeout, timeout counter.
- Reset mid-operation abandons the transaction. No dm response is produced for it, and any bus_rvalid arriving afterwards is ignored.
- dm_req_ready is combinational and equals (state == IDLE) && !rst.
- FSM states: IDLE, BUS_REQ, WAIT_RESP, RESP.
- IDLE:
  - On dm_req_valid && dm_req_ready, latch addr, wdata, wmask and wen.
  - For loads, force the latched wmask to 0.
  - Go to BUS_REQ.
- BUS_REQ:
  - bus_valid = 1; all bus outputs are stable from the latch.
  - On bus_ready, go to WAIT_RESP and clear the counter.
  - bus_valid deasserts in the cycle after the accept.
- WAIT_RESP:
  - bus_valid = 0; the counter increments each cycle.
  - On bus_rvalid: register dm_resp_rdata = wen ? 0 : bus_rdata, and go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: register dm_resp_rdata = 0, pulse bus_timeout for one cycle, and go to RESP.
  - bus_rvalid takes priority over timeout when both occur in the same cycle.
- RESP:
  - dm_resp_valid = 1 for exactly one cycle, then return to IDLE.
  - dm_req_ready rises in the following cycle.
- bus_rvalid outside WAIT_RESP is ignored, including a late response after a timeout.
- At most one request is outstanding. The dm side never sees two responses for one request.
- Minimum latency: accept at cycle N → bus_valid at N+1 (bus_ready=1) → bus_rvalid at N+2 → dm_resp_valid at N+3 → next accept at N+4.
- dm_req_* inputs are don't-care outside IDLE. The upstream pipeline holds them, but the bridge relies only on the latched copy.
- bus_addr always has bits [2:0] = 0. Byte selection is done upstream via wmask on writes and offset extraction on reads.
- A timeout completes the access without raising an exception. Only bus_timeout reports it.

Test Plan:
- Load: accept addr 0x8000_0013, wen=0, wmask=8'h02, with bus_ready=1 and bus_rvalid one cycle after accept carrying rdata 0x1122334455667788. Expected: bus_addr=0x8000_0010, bus_wmask=0; dm_resp_valid pulses exactly 3 cycles after dm accept with rdata 0x1122334455667788; dm_req_ready is 0 throughout.
- Store: wdata 0xAAAA…AA, wmask 0xF0, wen=1. Expected: bus_wen=1, bus_wmask=0xF0, bus_wdata matches; dm_resp_rdata=0 on completion.
- Bus backpressure: hold bus_ready=0 for 5 cycles. Expected: bus_valid and all bus fields stay stable for 6 cycles and deassert the cycle after accept; a single response follows.
- Timeout with TIMEOUT_CYCLES=4: bus_rvalid never arrives. Expected: bus_timeout pulses on the 4th WAIT_RESP cycle, dm_resp_valid fires the next cycle with rdata=0, and a bus_rvalid injected 2 cycles later produces no response.
- Simultaneous events: bus_rvalid arrives on the timeout cycle with rdata 0x5. Expected: dm_resp_rdata=0x5 and bus_timeout stays 0.
- Reset mid-WAIT_RESP: assert rst for 1 cycle, then deliver bus_rvalid. Expected: no dm_resp_valid, bus_valid=0, dm_req_ready=1 the cycle after rst deasserts; back-to-back requests then each complete in 4 cycles.
